unsaved_cpu_mulx_seq: RTL

- Multi-cycle multiply sequencer that sits directly upstream of the CPU's 32-bit multiply cell, `unsaved_cpu_mult_cell`.
- The cell returns only the low 32 bits of a 16-bit-split product. This block drives it with four zero-extended 16x16 partial products, accumulates a 64-bit sum and applies signed correction.
- It returns either the low word (MUL) or the high word (MULXUU/MULXSS/MULXSU) to the M-stage, with a busy/done handshake.

---
 rtl/unsaved_cpu_mulx_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/unsaved_cpu_mulx_seq.sv
`default_nettype none
// ============================================================================
// Module   : unsaved_cpu_mulx_seq
// Brief    : 32x32 multiply sequencer feeding four 16x16 partial products
//            to the CPU multiply cell; returns low word or signed/unsigned
//            high word. Optional macro MULX_SEQ_LO_FAST_EN adds a 3-cycle
//            MUL path straight through the cell.
// Revision : 1.0 - initial release
// ============================================================================
module unsaved_cpu_mulx_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   input  logic [31:0] cell_result
);

   localparam logic [1:0] c_OP_MUL    = 2'b00;
   localparam logic [1:0] c_OP_MULXSS = 2'b10;
   localparam logic [1:0] c_OP_MULXSU = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_ISSUE      = 3'd1,
      S_DRAIN      = 3'd2,
      S_CORR       = 3'd3
`ifdef MULX_SEQ_LO_FAST_EN
      ,
      S_FAST_ISSUE = 3'd4,
      S_FAST_CAP   = 3'd5
`endif
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [1:0]  r_op;
   logic [1:0]  r_k;
   logic [63:0] r_acc;
   logic        r_acc_en;
   logic [1:0]  r_acc_k;
   logic [31:0] r_result;
   logic        r_done;
   logic        w_accept;
   logic [63:0] w_pp_shifted;
   logic [31:0] w_sub_a;
   logic [31:0] w_sub_b;
   logic [31:0] w_hi_corr;
   logic [31:0] w_corr_result;

   assign w_accept = (r_state == S_IDLE) && start;
   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign result   = r_result;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      cell_src1    = 32'd0;
      cell_src2    = 32'd0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
`ifdef MULX_SEQ_LO_FAST_EN
               if (op == c_OP_MUL) w_next_state = S_FAST_ISSUE;
               else                w_next_state = S_ISSUE;
`else
               w_next_state = S_ISSUE;
`endif
            end
         end
         S_ISSUE: begin
            // Upper operand halves stay zero so the cell's cross term vanishes.
            case (r_k)
               2'd0: begin cell_src1 = {16'd0, r_a[15:0]};  cell_src2 = {16'd0, r_b[15:0]};  end
               2'd1: begin cell_src1 = {16'd0, r_a[31:16]}; cell_src2 = {16'd0, r_b[15:0]};  end
               2'd2: begin cell_src1 = {16'd0, r_a[15:0]};  cell_src2 = {16'd0, r_b[31:16]}; end
               default: begin cell_src1 = {16'd0, r_a[31:16]}; cell_src2 = {16'd0, r_b[31:16]}; end
            endcase
            if (r_k == 2'd3) w_next_state = S_DRAIN;
         end
         S_DRAIN: w_next_state = S_CORR;
         S_CORR:  w_next_state = S_IDLE;
`ifdef MULX_SEQ_LO_FAST_EN
         S_FAST_ISSUE: begin
            cell_src1    = r_a;
            cell_src2    = r_b;
            w_next_state = S_FAST_CAP;
         end
         S_FAST_CAP: w_next_state = S_IDLE;
`endif
         default: w_next_state = S_IDLE;
      endcase
   end

   // The cell answers one cycle late, so the shift follows the previous k.
   always_comb begin
      case (r_acc_k)
         2'd0:    w_pp_shifted = {32'd0, cell_result};
         2'd3:    w_pp_shifted = {cell_result, 32'd0};
         default: w_pp_shifted = {16'd0, cell_result, 16'd0};
      endcase
   end

   assign w_sub_b   = (((r_op == c_OP_MULXSS) || (r_op == c_OP_MULXSU)) && r_a[31]) ? r_b : 32'd0;
   assign w_sub_a   = ((r_op == c_OP_MULXSS) && r_b[31]) ? r_a : 32'd0;
   assign w_hi_corr = r_acc[63:32] - w_sub_b - w_sub_a;
   assign w_corr_result = (r_op == c_OP_MUL) ? r_acc[31:0] : w_hi_corr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_op     <= 2'd0;
         r_k      <= 2'd0;
         r_acc    <= 64'd0;
         r_acc_en <= 1'b0;
         r_acc_k  <= 2'd0;
         r_result <= 32'd0;
         r_done   <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_acc_en <= (r_state == S_ISSUE);
         r_acc_k  <= r_k;
         if (w_accept) begin
            r_a   <= src1;
            r_b   <= src2;
            r_op  <= op;
            r_k   <= 2'd0;
            r_acc <= 64'd0;
         end else begin
            if (r_state == S_ISSUE) r_k   <= r_k + 2'd1;
            if (r_acc_en)           r_acc <= r_acc + w_pp_shifted;
         end
         if (r_state == S_CORR) begin
            r_result <= w_corr_result;
            r_done   <= 1'b1;
         end
`ifdef MULX_SEQ_LO_FAST_EN
         if (r_state == S_FAST_CAP) begin
            r_result <= cell_result;
            r_done   <= 1'b1;
         end
`endif
      end
   end

endmodule
`default_nettype wire
